fft8_frame_ctrl: RTL and testbench
==================================

// Module: fft8_frame_ctrl
// PURPOSE
//  Frame sequencer for the 8-point FFT/IFFT butterfly datapath (three registered stages).
//  - Collects 8 serial complex samples through a valid/ready input stream.
//  - Presents them in parallel to the datapath and fires its enable.
//  - Captures the 8 results a fixed latency later and streams them out serially with valid/ready.
//  - IFFT mode: conjugate in, conjugate out, scale by 1/8, all on the shared forward datapath.
//  - Sits between the sample interface and the stage-1 butterfly.
// PARAMETERS
//  DW          16   sample component width, signed Q1.15
//  PIPE_LAT    3    clocks from the dp_en edge to valid dp_y (one per butterfly stage)
//  OUT_BITREV  1    1: output index k reads result slot bitrev3(k); 0: natural order
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       reset, asynchronous, active-high
//  in_valid    in   1       input sample valid
//  in_ready    out  1       controller can accept a sample
//  in_re       in   DW      input real part
//  in_im       in   DW      input imaginary part
//  in_mode     in   1       0=FFT, 1=IFFT; sampled with sample 0 of a frame only
//  out_valid   out  1       output sample valid
//  out_ready   in   1       downstream accepts the output sample
//  out_re      out  DW      output real part
//  out_im      out  DW      output imaginary part
//  out_last    out  1       marks sample 7 of an output frame
//  dp_en       out  1       one-cycle datapath enable
//  dp_x_re     out  8*DW    parallel datapath inputs, slot n at [n*DW +: DW]
//  dp_x_im     out  8*DW    parallel datapath inputs, imaginary
//  dp_y_re     in   8*DW    parallel datapath results, real
//  dp_y_im     in   8*DW    parallel datapath results, imaginary
//  busy        out  1       any frame held in the input buffer, compute or drain
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, out_last=0, dp_en=0, busy=0, all buffers/counters 0.
//  - Reset is async; asserting it mid-frame discards all frames.
//  Input FSM (FILL, FULL):
//  - FILL: in_ready=1; each in_valid&&in_ready writes slot ld_cnt; ld_cnt wraps 7->0.
//  - Write of slot 7 -> FULL, in_ready=0 from the next cycle.
//  - Frame mode bit = in_mode at slot 0.
//  - FIFO conditioning: IFFT frames store im negated, saturating (-32768 -> 32767); re unchanged.
//  - FULL -> FILL in the cycle after dp_en. The datapath samples dp_x only at the dp_en edge.
//  - dp_x_* is driven straight from the input buffer.
//  Compute FSM (IDLE, FIRE, WAIT, DRAIN):
//  - IDLE -> FIRE when input FSM is FULL.
//  - FIRE: dp_en=1 for exactly one cycle. The frame mode bit is copied to the compute side.
//  - WAIT: lat_cnt counts PIPE_LAT cycles after FIRE. On the last count, dp_y_* is latched into the output buffer.
//  - Then -> DRAIN. Result latency from FIRE to first out_valid = PIPE_LAT+1 cycles.
//  - DRAIN: out_valid=1, out_re/out_im = conditioned obuf[idx(rd_cnt)].
//  - rd_cnt advances on out_valid&&out_ready; out_last=1 when rd_cnt==7.
//  - Handshake at rd_cnt==7 -> IDLE, or straight to FIRE in the same edge if input is FULL.
//  - Backpressure: out_re/out_im/out_last are held stable while out_valid&&!out_ready.
//  - Overlap: the input side fills the next frame during WAIT/DRAIN. At most 2 frames are in flight.
//  Output conditioning:
//  - FFT: pass through.
//  - IFFT: re=(y_re+4)>>>3 and im=-((y_im+4)>>>3), computed at DW+1 bits, then saturated to DW.
//  busy = (input FSM FULL) | (ld_cnt!=0) | (compute FSM != IDLE).
//  Simultaneous events:
//  - Last input handshake on the same edge as the drain end: FULL is set that edge, FIRE follows one cycle later.
//  - in_mode changes mid-frame are ignored.
// STRUCTURE
//  - Shared package fft8_pkg: DW, N=8, state enums for both FSMs, bitrev3 function, sat_neg function.
//  - One sub-module fft8_out_cond (combinational): mode-based conjugate/scale/saturate of one sample.
//  - Buffers and FSMs stay in this module.
// TESTING
//  - Bench uses a behavioural 8-pt DFT model with PIPE_LAT registers in place of the datapath.
//  - Impulse FFT: x0=1000+0j, others 0 -> 8 outputs 1000+0j, out_last only on the 8th; first out_valid 4 cycles after dp_en.
//  - DC IFFT: X0=8000+0j, others 0, in_mode=1 -> all outputs 1000+0j; input im=-32768 stored as 32767.
//  - Backpressure: out_ready=0 for 5 cycles at rd_cnt=3 -> out_valid stays 1, out_re/im/last stable, no sample lost or duplicated.
//  - Back-to-back frames: 16 samples with in_valid constantly 1 and out_ready=1.
//    -> in_ready drops only while input is FULL; dp_en pulses twice; 16 outputs in order.
//  - Mode per frame: FFT frame then IFFT frame, in_mode toggled mid-frame -> each frame uses its slot-0 mode.
//  - Reset during DRAIN at rd_cnt=5 -> out_valid=0, busy=0, in_ready=1 after release; the next frame processes cleanly.

Source files
------------

// File: rtl/fft8_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fft8_pkg: shared widths, FSM encodings and helpers for the 8-pt FFT     |
// | frame controller.                                    Revision: 1.0      |
// +-------------------------------------------------------------------------+
package fft8_pkg;

  localparam int DW = 16;
  localparam int N  = 8;

  typedef enum logic {
    IN_FILL = 1'b0,
    IN_FULL = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    CMP_IDLE  = 2'd0,
    CMP_FIRE  = 2'd1,
    CMP_WAIT  = 2'd2,
    CMP_DRAIN = 2'd3
  } cmp_state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  // Negation that maps the most negative code onto the most positive one.
  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] v);
    if (v == {1'b1, {(DW-1){1'b0}}})
      return {1'b0, {(DW-1){1'b1}}};
    return -v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft8_out_cond.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fft8_out_cond: per-sample output conditioning (IFFT conjugate, 1/8      |
// | scale with rounding, saturation).                    Revision: 1.0      |
// +-------------------------------------------------------------------------+
module fft8_out_cond #(
  parameter int DW = 16
) (
  input  logic          mode,
  input  logic [DW-1:0] y_re,
  input  logic [DW-1:0] y_im,
  output logic [DW-1:0] c_re,
  output logic [DW-1:0] c_im
);

  localparam logic signed [DW:0] RND = 4;

  logic signed [DW:0] re_wide;
  logic signed [DW:0] im_wide;

  function automatic logic [DW-1:0] sat(input logic signed [DW:0] v);
    if (v[DW] != v[DW-1])
      return v[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    return v[DW-1:0];
  endfunction

  always_comb begin
    re_wide = ($signed({y_re[DW-1], y_re}) + RND) >>> 3;
    im_wide = -(($signed({y_im[DW-1], y_im}) + RND) >>> 3);
    c_re    = mode ? sat(re_wide) : y_re;
    c_im    = mode ? sat(im_wide) : y_im;
  end

endmodule
`default_nettype wire

// File: rtl/fft8_frame_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fft8_frame_ctrl: serial-to-parallel frame sequencer around the 3-stage  |
// | 8-pt butterfly datapath, with IFFT via conjugation.  Revision: 1.0      |
// +-------------------------------------------------------------------------+
module fft8_frame_ctrl
  import fft8_pkg::*;
#(
  parameter int DW         = 16,
  parameter int PIPE_LAT   = 3,
  parameter bit OUT_BITREV = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  input  logic          in_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic          out_last,
  output logic          dp_en,
  output logic [N*DW-1:0] dp_x_re,
  output logic [N*DW-1:0] dp_x_im,
  input  logic [N*DW-1:0] dp_y_re,
  input  logic [N*DW-1:0] dp_y_im,
  output logic          busy
);

  localparam int LW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  in_state_t  in_st,  in_nx;
  cmp_state_t cmp_st, cmp_nx;

  logic [2:0]      ld_cnt;
  logic [2:0]      rd_cnt;
  logic [2:0]      rd_idx;
  logic [LW-1:0]   lat_cnt;
  logic            lat_done;
  logic            mode_in;
  logic            mode_cmp;
  logic            in_fire;
  logic            slot_mode;
  logic [DW-1:0]   cond_im;
  logic [N*DW-1:0] ibuf_re;
  logic [N*DW-1:0] ibuf_im;
  logic [N*DW-1:0] obuf_re;
  logic [N*DW-1:0] obuf_im;

  assign in_fire   = in_valid && in_ready;
  // Slot 0 decides the frame mode, so its own conditioning must use the live pin.
  assign slot_mode = (ld_cnt == 3'd0) ? in_mode : mode_in;
  assign cond_im   = slot_mode ? sat_neg(in_im) : in_im;
  assign lat_done  = (lat_cnt == LW'(PIPE_LAT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_st  <= IN_FILL;
      cmp_st <= CMP_IDLE;
    end else begin
      in_st  <= in_nx;
      cmp_st <= cmp_nx;
    end
  end

  always_comb begin
    in_nx    = in_st;
    in_ready = 1'b0;
    case (in_st)
      IN_FILL: begin
        in_ready = 1'b1;
        if (in_valid && ld_cnt == 3'd7) in_nx = IN_FULL;
      end
      IN_FULL: if (dp_en) in_nx = IN_FILL;
      default: in_nx = IN_FILL;
    endcase
  end

  always_comb begin
    cmp_nx    = cmp_st;
    dp_en     = 1'b0;
    out_valid = 1'b0;
    case (cmp_st)
      CMP_IDLE: if (in_st == IN_FULL) cmp_nx = CMP_FIRE;
      CMP_FIRE: begin
        dp_en  = 1'b1;
        cmp_nx = CMP_WAIT;
      end
      CMP_WAIT: if (lat_done) cmp_nx = CMP_DRAIN;
      CMP_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && rd_cnt == 3'd7)
          cmp_nx = (in_st == IN_FULL) ? CMP_FIRE : CMP_IDLE;
      end
      default: cmp_nx = CMP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt  <= 3'd0;
      mode_in <= 1'b0;
      ibuf_re <= '0;
      ibuf_im <= '0;
    end else if (in_fire) begin
      ibuf_re[ld_cnt*DW +: DW] <= in_re;
      ibuf_im[ld_cnt*DW +: DW] <= cond_im;
      ld_cnt                   <= ld_cnt + 3'd1;
      if (ld_cnt == 3'd0) mode_in <= in_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt  <= '0;
      rd_cnt   <= 3'd0;
      mode_cmp <= 1'b0;
      obuf_re  <= '0;
      obuf_im  <= '0;
    end else begin
      if (cmp_st == CMP_FIRE) begin
        mode_cmp <= mode_in;
        lat_cnt  <= '0;
      end
      if (cmp_st == CMP_WAIT) begin
        lat_cnt <= lat_cnt + 1'b1;
        if (lat_done) begin
          obuf_re <= dp_y_re;
          obuf_im <= dp_y_im;
        end
      end
      if (out_valid && out_ready) rd_cnt <= rd_cnt + 3'd1;
    end
  end

  assign dp_x_re  = ibuf_re;
  assign dp_x_im  = ibuf_im;
  assign rd_idx   = OUT_BITREV ? bitrev3(rd_cnt) : rd_cnt;
  assign out_last = out_valid && (rd_cnt == 3'd7);
  assign busy     = (in_st == IN_FULL) || (ld_cnt != 3'd0) || (cmp_st != CMP_IDLE);

  fft8_out_cond #(.DW(DW)) u_cond (
    .mode (mode_cmp),
    .y_re (obuf_re[rd_idx*DW +: DW]),
    .y_im (obuf_im[rd_idx*DW +: DW]),
    .c_re (out_re),
    .c_im (out_im)
  );

endmodule
`default_nettype wire

// File: tb/tb_fft8_frame_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_fft8_frame_ctrl: frame controller against a DFT datapath stand-in    |
// | and a frame-level reference model.                   Revision: 1.0      |
// +-------------------------------------------------------------------------+
module tb_fft8_frame_ctrl;

  localparam int DW = 16;
  localparam int PL = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid, in_ready, in_mode;
  logic [DW-1:0] in_re, in_im;
  logic out_valid, out_ready, out_last, dp_en, busy;
  logic [DW-1:0] out_re, out_im;
  logic [8*DW-1:0] dp_x_re, dp_x_im, dp_y_re, dp_y_im;

  always #5 clk = ~clk;

  fft8_frame_ctrl #(.DW(DW), .PIPE_LAT(PL), .OUT_BITREV(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im), .out_last(out_last),
    .dp_en(dp_en), .dp_x_re(dp_x_re), .dp_x_im(dp_x_im), .dp_y_re(dp_y_re), .dp_y_im(dp_y_im),
    .busy(busy)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int brev(input int k);
    logic [2:0] b;
    b = k[2:0];
    return int'({b[0], b[1], b[2]});
  endfunction

  // X[k] = sum x[n] * exp(-j*2*pi*k*n/8), rounded to nearest
  function automatic int dft_bin(input logic [8*DW-1:0] xr, input logic [8*DW-1:0] xi,
                                 input int k, input bit want_im);
    real s = 0.0;
    real a, r, i;
    for (int n = 0; n < 8; n++) begin
      a = 2.0 * 3.14159265358979 * $itor(k * n) / 8.0;
      r = $itor($signed(xr[n*DW +: DW]));
      i = $itor($signed(xi[n*DW +: DW]));
      if (want_im) s = s + i * $cos(a) - r * $sin(a);
      else         s = s + r * $cos(a) + i * $sin(a);
    end
    return (s >= 0.0) ? $rtoi($floor(s + 0.5)) : -$rtoi($floor(-s + 0.5));
  endfunction

  // Datapath stand-in: result slot m carries bin bitrev(m)
  function automatic logic [8*DW-1:0] dp_slots(input logic [8*DW-1:0] xr,
                                               input logic [8*DW-1:0] xi, input bit want_im);
    logic [8*DW-1:0] v;
    for (int m = 0; m < 8; m++) v[m*DW +: DW] = DW'(clamp(dft_bin(xr, xi, brev(m), want_im)));
    return v;
  endfunction

  logic [8*DW-1:0] pr [PL];
  logic [8*DW-1:0] pi [PL];
  assign dp_y_re = pr[PL-1];
  assign dp_y_im = pi[PL-1];

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    pr[0] <= dp_en ? dp_slots(dp_x_re, dp_x_im, 1'b0) : '0;
    pi[0] <= dp_en ? dp_slots(dp_x_re, dp_x_im, 1'b1) : '0;
    for (int s = 1; s < PL; s++) begin
      pr[s] <= pr[s-1];
      pi[s] <= pi[s-1];
    end
  end

  // Reference model state: sample/fire/pop counts plus queue of expected outputs
  int acc = 0, popped = 0, fires = 0, last_fire_cyc = 0, fire_im3 = 0;
  int m_re [8];
  int m_im [8];
  bit m_mode;
  int exp_re [$];
  int exp_im [$];
  int cap_re [$];
  int cap_im [$];
  int cap_last [$];

  task automatic push_frame();
    logic [8*DW-1:0] cr, ci;
    int yr, yi;
    for (int n = 0; n < 8; n++) begin
      cr[n*DW +: DW] = DW'(m_re[n]);
      ci[n*DW +: DW] = DW'(m_mode ? ((m_im[n] == -32768) ? 32767 : -m_im[n]) : m_im[n]);
    end
    for (int k = 0; k < 8; k++) begin
      yr = clamp(dft_bin(cr, ci, k, 1'b0));
      yi = clamp(dft_bin(cr, ci, k, 1'b1));
      if (m_mode) begin
        yr = clamp((yr + 4) >>> 3);
        yi = clamp(-((yi + 4) >>> 3));
      end
      exp_re.push_back(yr);
      exp_im.push_back(yi);
    end
  endtask

  initial begin : compare
    bit prev_ov, prev_stall, prev_dpen;
    int h_re, h_im, h_last, slot;
    prev_ov = 0; prev_stall = 0; prev_dpen = 0;
    h_re = 0; h_im = 0; h_last = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        acc = 0; popped = 0; fires = 0;
        exp_re.delete(); exp_im.delete();
        prev_ov = 0; prev_stall = 0; prev_dpen = 0;
      end else begin
        chk("in_ready", int'(in_ready), int'((acc - 8 * fires) < 8));
        chk("busy", int'(busy), int'(acc != popped));
        if (dp_en) begin
          chk("dp_en_pulse", int'(prev_dpen), 0);
          chk("dp_en_frame_full", acc - 8 * fires, 8);
          fires++;
          last_fire_cyc = cyc;
          fire_im3 = int'($signed(dp_x_im[3*DW +: DW]));
        end
        if (in_valid && in_ready) begin
          slot = acc % 8;
          if (slot == 0) m_mode = in_mode;
          m_re[slot] = int'($signed(in_re));
          m_im[slot] = int'($signed(in_im));
          acc++;
          if (slot == 7) push_frame();
        end
        if (out_valid) begin
          if (!prev_ov) chk("first_out_latency", cyc - last_fire_cyc, PL + 1);
          if (prev_stall) begin
            chk("stall_re", int'($signed(out_re)), h_re);
            chk("stall_im", int'($signed(out_im)), h_im);
            chk("stall_last", int'(out_last), h_last);
          end
          if (out_ready) begin
            if (exp_re.size() == 0) chk("unexpected_output", 1, 0);
            else begin
              chk("out_re", int'($signed(out_re)), exp_re.pop_front());
              chk("out_im", int'($signed(out_im)), exp_im.pop_front());
              chk("out_last", int'(out_last), int'(popped % 8 == 7));
            end
            cap_re.push_back(int'($signed(out_re)));
            cap_im.push_back(int'($signed(out_im)));
            cap_last.push_back(int'(out_last));
            popped++;
          end
        end else if (prev_stall) chk("stall_valid_drop", 0, 1);
        prev_ov    = out_valid;
        prev_stall = out_valid && !out_ready;
        prev_dpen  = dp_en;
        h_re = int'($signed(out_re)); h_im = int'($signed(out_im)); h_last = int'(out_last);
      end
    end
  end

  bit bp_hold = 0, rnd_rdy = 0, gaps = 0;
  initial begin : ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (bp_hold)      out_ready = 1'b0;
      else if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
      else              out_ready = 1'b1;
    end
  end

  int fr_re [64];
  int fr_im [64];
  bit fr_md [64];

  task automatic send_n(input int n);
    int t;
    bit ok;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_re = DW'(fr_re[i]); in_im = DW'(fr_im[i]); in_mode = fr_md[i];
      t = 0; ok = 0;
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) chk("in_accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (((acc != popped) || busy || out_valid) && t < 600) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 600) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_rd(input int idx);
    int t = 0;
    while (!(out_valid && (popped % 8) == idx) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) chk("rd_wait_timeout", 0, 1);
  endtask

  task automatic rand_fill(input int n);
    for (int i = 0; i < n; i++) begin
      fr_re[i] = int'($urandom_range(5000)) - 2500;
      fr_im[i] = int'($urandom_range(5000)) - 2500;
      fr_md[i] = 1'($urandom_range(1));
    end
  endtask

  task automatic clear_cap();
    cap_re.delete(); cap_im.delete(); cap_last.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int f0;
    in_valid = 0; in_re = 0; in_im = 0; in_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_dp_en", int'(dp_en), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 0;
    @(posedge clk); #1;

    // impulse, FFT
    for (int i = 0; i < 8; i++) begin fr_re[i] = 0; fr_im[i] = 0; fr_md[i] = 0; end
    fr_re[0] = 1000;
    clear_cap(); send_n(8); wait_drain();
    chk("imp_count", cap_re.size(), 8);
    for (int k = 0; k < 8 && k < cap_re.size(); k++) begin
      chk("imp_re", cap_re[k], 1000);
      chk("imp_im", cap_im[k], 0);
      chk("imp_last", cap_last[k], int'(k == 7));
    end

    // DC, IFFT
    for (int i = 0; i < 8; i++) begin fr_re[i] = 0; fr_im[i] = 0; fr_md[i] = 1; end
    fr_re[0] = 8000;
    clear_cap(); send_n(8); wait_drain();
    chk("dc_count", cap_re.size(), 8);
    for (int k = 0; k < 8 && k < cap_re.size(); k++) begin
      chk("dc_ifft_re", cap_re[k], 1000);
      chk("dc_ifft_im", cap_im[k], 0);
    end

    // most-negative imaginary input in an IFFT frame
    rand_fill(8); fr_md[0] = 1; fr_im[3] = -32768;
    send_n(8); wait_drain();
    chk("ifft_im_sat_store", fire_im3, 32767);

    // backpressure at output index 3
    rand_fill(8); fr_md[0] = 0;
    clear_cap(); send_n(8);
    wait_rd(3);
    bp_hold = 1;
    repeat (5) @(posedge clk);
    #1 bp_hold = 0;
    wait_drain();
    chk("bp_count", cap_re.size(), 8);

    // back-to-back, FFT then IFFT with in_mode wandering after slot 0
    rand_fill(16); fr_md[0] = 0; fr_md[8] = 1;
    f0 = fires;
    clear_cap(); send_n(16); wait_drain();
    chk("b2b_fires", fires - f0, 2);
    chk("b2b_count", cap_re.size(), 16);

    // random frames, random gaps and output stalls
    rnd_rdy = 1; gaps = 1;
    rand_fill(48); send_n(48); wait_drain();
    rnd_rdy = 0; gaps = 0;

    // reset in the middle of a drain
    rand_fill(8); send_n(8);
    wait_rd(5);
    reset = 1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin fr_re[i] = 0; fr_im[i] = 0; fr_md[i] = 0; end
    fr_re[0] = 1000;
    clear_cap(); send_n(8); wait_drain();
    chk("post_rst_count", cap_re.size(), 8);
    for (int k = 0; k < 8 && k < cap_re.size(); k++) chk("post_rst_re", cap_re[k], 1000);

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
